// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: sequential instruction fetch front end. It keeps several
// memory reads in flight and buffers the in-order responses (with their PCs)
// in a small queue that feeds decode one uop per cycle. A redirect flushes the
// queue and marks every in-flight read for discard.
module fetch_prefetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 32,
  parameter int                    QUEUE_DEPTH     = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP         = ADDR_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [INST_WIDTH-1:0] mem_rsp_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush_out,
  output logic                  uop_valid_out,
  output logic [INST_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(QUEUE_DEPTH);
  localparam logic [OUT_W-1:0]      OUT_ONE    = OUT_W'(1);
  localparam logic [OUT_W-1:0]      OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0]      SUM_LIMIT  = SUM_W'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t                queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      drop_cnt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [SUM_W-1:0]      credit_sum;
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  // Credit check and per-cycle handshake decisions
  // NOTE: every signal gets a value before any condition, so no latch can be inferred.
  always_comb begin
    credit_sum      = SUM_W'(count) + SUM_W'(outstanding);
    mem_req_valid   = !reset && !redirect_valid && (outstanding < OUT_MAX) &&
                      (credit_sum < SUM_LIMIT);
    req_fire        = mem_req_valid && mem_req_ready;
    push            = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    pop             = !redirect_valid && !stall && (count != '0);
    redirect_target = redirect_pc & ALIGN_MASK;
  end

  assign mem_req_addr = fetch_pc;
  assign flush_out    = redirect_valid;

  // Queue storage: written only on a kept response
  // NOTE: storage has no reset; count and pointers decide what is valid, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= '{pc: rsp_pc, inst: mem_rsp_data};
  end

  // Fetch/response bookkeeping, queue pointers and registered decode outputs
  // NOTE: all state uses non-blocking assignment, so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      rsp_pc        <= RESET_PC;
      outstanding   <= '0;
      drop_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      uop_valid_out <= 1'b0;
      opcode        <= '0;
      pc_out        <= '0;
    end else begin
      // No request can fire during a redirect, so this is correct in both paths
      unique case ({req_fire, mem_rsp_valid})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        fetch_pc      <= redirect_target;
        rsp_pc        <= redirect_target;
        // Whatever is still in flight after this edge belongs to the old path
        drop_cnt      <= mem_rsp_valid ? (outstanding - OUT_ONE) : outstanding;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        uop_valid_out <= 1'b0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (mem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OUT_ONE;
        if (push) begin
          rsp_pc <= rsp_pc + PC_STEP;
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          opcode <= queue_mem[rd_ptr].inst;
          pc_out <= queue_mem[rd_ptr].pc;
        end
        if (!stall) uop_valid_out <= pop;
        unique case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Credit rule guarantees a free slot for every returning response
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && (count == CNT_FULL)));
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed phases plus a randomized phase, checked
// against a queue-based behavioural model of the fetch front end.
module tb_fetch_prefetch_unit;

  localparam int          AW      = 32;
  localparam int          IW      = 32;
  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [IW-1:0] mem_rsp_data;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          flush_out;
  logic          uop_valid_out;
  logic [IW-1:0] opcode;
  logic [AW-1:0] pc_out;

  fetch_prefetch_unit #(
    .ADDR_WIDTH     (AW),
    .INST_WIDTH     (IW),
    .QUEUE_DEPTH    (DEPTH),
    .MAX_OUTSTANDING(MAX_OUT),
    .RESET_PC       (RST_PC),
    .PC_STEP        (32'd4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush_out     (flush_out),
    .uop_valid_out (uop_valid_out),
    .opcode        (opcode),
    .pc_out        (pc_out)
  );

  always #5 clk = ~clk;

  // Reference model: reads in flight (tagged live/dead), buffered uops, outputs
  typedef struct { logic [31:0] addr; bit live; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } uop_t;

  req_t        inflight[$];
  uop_t        uopq[$];
  logic [31:0] m_fetch;
  logic        m_valid;
  logic [31:0] m_opcode;
  logic [31:0] m_pc;

  // Memory model: addresses actually accepted from the DUT, answered in order
  logic [31:0] mem_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    uopq.delete();
    mem_q.delete();
    m_fetch  = RST_PC;
    m_valid  = 1'b0;
    m_opcode = '0;
    m_pc     = '0;
  endtask

  // One clock: check request side before the edge, advance model, check outputs after
  task automatic step();
    logic        exp_rv;
    logic        fire;
    logic        act_fire;
    logic [31:0] act_addr;
    req_t        head;
    bit          have_head;
    #1;
    exp_rv = !redirect_valid && (inflight.size() < MAX_OUT) &&
             ((uopq.size() + inflight.size()) < DEPTH);
    check("req_valid", mem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", mem_req_addr, m_fetch);
    check("flush_out", flush_out, redirect_valid);
    act_fire = mem_req_valid && mem_req_ready;
    act_addr = mem_req_addr;
    fire     = exp_rv && mem_req_ready;

    @(posedge clk);
    have_head = 1'b0;
    if (mem_rsp_valid && (inflight.size() > 0)) begin
      head      = inflight.pop_front();
      have_head = 1'b1;
    end
    if (redirect_valid) begin
      foreach (inflight[i]) inflight[i].live = 1'b0;
      uopq.delete();
      m_valid = 1'b0;
      m_fetch = redirect_pc & ~32'h3;
    end else begin
      if (!stall) begin
        if (uopq.size() > 0) begin
          uop_t u;
          u        = uopq.pop_front();
          m_opcode = u.inst;
          m_pc     = u.pc;
          m_valid  = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (have_head && head.live) uopq.push_back('{pc: head.addr, inst: inst_of(head.addr)});
      if (fire) begin
        inflight.push_back('{addr: m_fetch, live: 1'b1});
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (mem_rsp_valid && (mem_q.size() > 0)) void'(mem_q.pop_front());
    if (act_fire) mem_q.push_back(act_addr);

    #1;
    check("uop_valid", uop_valid_out, m_valid);
    check("opcode", opcode, m_opcode);
    check("pc_out", pc_out, m_pc);
    @(negedge clk);
  endtask

  // Apply one cycle of inputs (at negedge) and run it
  task automatic drive(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit rdy, input int rsp_pct);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    mem_req_ready  = rdy;
    if ((mem_q.size() > 0) && (int'($urandom_range(99, 0)) < rsp_pct)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(mem_q[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    step();
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();

    // Reset state
    #1;
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_uop_valid", uop_valid_out, 1'b0);
    check("rst_opcode", opcode, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Streaming with a 1-cycle memory
    repeat (20) drive(0, 0, 32'h0, 1, 100);

    // Stall fills the queue, then drain
    repeat (10) drive(1, 0, 32'h0, 1, 100);
    repeat (8)  drive(0, 0, 32'h0, 1, 100);

    // Two reads in flight, then redirect to 0x100
    repeat (2) drive(0, 0, 32'h0, 1, 0);
    drive(0, 1, 32'h100, 1, 0);
    repeat (8) drive(0, 0, 32'h0, 1, 100);

    // Unaligned redirect target
    drive(0, 1, 32'h203, 1, 100);
    repeat (6) drive(0, 0, 32'h0, 1, 100);

    // Redirect together with stall and a returning response
    repeat (3) drive(1, 0, 32'h0, 1, 0);
    drive(1, 1, 32'h300, 1, 100);
    repeat (8) drive(0, 0, 32'h0, 1, 100);

    // Memory back-pressure: address must hold
    repeat (5) drive(0, 0, 32'h0, 0, 100);
    repeat (4) drive(0, 0, 32'h0, 1, 100);

    // Back-to-back redirects with reads in flight
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 1, 32'h400, 1, 50);
    drive(0, 1, 32'h500, 1, 50);
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 1, 32'h602, 1, 100);
    repeat (10) drive(0, 0, 32'h0, 1, 100);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, $urandom,
            $urandom_range(3, 0) != 0, 60);
    end

    // Async reset in the middle of a burst
    repeat (6) drive(0, 0, 32'h0, 1, 100);
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_uop_valid", uop_valid_out, 1'b0);
    check("async_opcode", opcode, 32'h0);
    check("async_pc_out", pc_out, 32'h0);
    check("async_req_valid", mem_req_valid, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Restart from RESET_PC
    repeat (10) drive(0, 0, 32'h0, 1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
